// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Bridges the pipeline's 32-bit load/store requests onto a 16-bit asynchronous
// SRAM. Each word access is split into two halfword phases (low half first),
// and each phase holds the SRAM strobes for WAIT_CYCLES clock cycles. While an
// access is pending the pipeline is frozen.
//
// Data memory is mapped at byte address 1024, so the SRAM sees
// (address - 1024) with the byte offset dropped and a halfword select appended.
//
// Parameters:
//   WAIT_CYCLES  cycles per 16-bit half-access (1..15)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   wr_en        store request (wins if rd_en is also high)
//   rd_en        load request
//   address      byte address from the ALU
//   write_data   store data
//   read_data    load data, registered
//   ready        no access pending, or access completing this cycle
//   freeze       pipeline stall, inverse of ready
//   sram_addr    SRAM halfword address
//   sram_dq_out  SRAM write data
//   sram_dq_in   SRAM read data
//   sram_dq_oe   drive sram_dq_out onto the pad
//   sram_we_n    SRAM write strobe, active-low
//   sram_oe_n    SRAM output enable, active-low
// -----------------------------------------------------------------------------
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        freeze,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : gen_bad_wait
        $error("sram_controller: WAIT_CYCLES must be in 1..15");
    end

    localparam logic [3:0]  LAST_COUNT  = 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] BASE_OFFSET = 32'd1024;

    typedef enum logic [1:0] {
        StIdle,
        StAccLo,
        StAccHi,
        StDone
    } state_t;

    state_t      state_q;
    logic [3:0]  count_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        is_write_q;

    // Effective address of the incoming request (used when leaving idle) and
    // of the latched request (used for the high half).
    logic [31:0] eff_in;
    logic [31:0] eff_q;
    logic        req;
    logic        last_cycle;

    assign eff_in     = address - BASE_OFFSET;
    assign eff_q      = addr_q - BASE_OFFSET;
    assign req        = wr_en | rd_en;
    assign last_cycle = (count_q == LAST_COUNT);

    // Byte offset and bits above the SRAM window do not reach the SRAM.
    logic unused_eff;
    assign unused_eff = ^{eff_in[31:19], eff_in[1:0], eff_q[31:19], eff_q[1:0]};

    assign ready  = (state_q == StDone) || ((state_q == StIdle) && !req);
    assign freeze = ~ready;

    // Single FSM block: state, latches and all SRAM-side outputs are
    // registered so the strobes line up exactly with the access states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= 4'd0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            is_write_q  <= 1'b0;
            read_data   <= 32'd0;
            sram_addr   <= 18'd0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q     <= address;
                        data_q     <= write_data;
                        is_write_q <= wr_en;
                        count_q    <= 4'd0;
                        state_q    <= StAccLo;
                        sram_addr  <= {eff_in[18:2], 1'b0};
                        if (wr_en) begin
                            sram_dq_out <= write_data[15:0];
                            sram_we_n   <= 1'b0;
                            sram_dq_oe  <= 1'b1;
                            sram_oe_n   <= 1'b1;
                        end else begin
                            sram_we_n   <= 1'b1;
                            sram_dq_oe  <= 1'b0;
                            sram_oe_n   <= 1'b0;
                        end
                    end
                end

                StAccLo: begin
                    if (last_cycle) begin
                        count_q   <= 4'd0;
                        state_q   <= StAccHi;
                        sram_addr <= {eff_q[18:2], 1'b1};
                        if (is_write_q) begin
                            sram_dq_out <= data_q[31:16];
                        end else begin
                            read_data[15:0] <= sram_dq_in;
                        end
                    end else begin
                        count_q <= count_q + 4'd1;
                    end
                end

                StAccHi: begin
                    if (last_cycle) begin
                        count_q    <= 4'd0;
                        state_q    <= StDone;
                        sram_we_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (!is_write_q) begin
                            read_data[31:16] <= sram_dq_in;
                        end
                    end else begin
                        count_q <= count_q + 4'd1;
                    end
                end

                StDone: begin
                    // A request still held here is picked up by idle next cycle.
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//
// Directed bench for sram_controller. One instance uses WAIT_CYCLES=2 against
// a small halfword memory model; a second uses WAIT_CYCLES=1 with fixed SRAM
// read data for back-to-back reads. Inputs change and outputs are checked 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;

    logic        rst2;
    logic        rd_en2;
    logic [31:0] address2;
    logic [31:0] read_data2;
    logic        ready2;
    logic        freeze2;
    logic [17:0] sram_addr2;
    logic [15:0] sram_dq_out2;
    logic [15:0] sram_dq_in2;
    logic        sram_dq_oe2;
    logic        sram_we_n2;
    logic        sram_oe_n2;

    int compared;
    int mismatched;

    logic [15:0] mem [16];

    sram_controller #(.WAIT_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .freeze      (freeze),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    sram_controller #(.WAIT_CYCLES(1)) dut2 (
        .clk         (clk),
        .rst         (rst2),
        .wr_en       (1'b0),
        .rd_en       (rd_en2),
        .address     (address2),
        .write_data  (32'd0),
        .read_data   (read_data2),
        .ready       (ready2),
        .freeze      (freeze2),
        .sram_addr   (sram_addr2),
        .sram_dq_out (sram_dq_out2),
        .sram_dq_in  (sram_dq_in2),
        .sram_dq_oe  (sram_dq_oe2),
        .sram_we_n   (sram_we_n2),
        .sram_oe_n   (sram_oe_n2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Halfword SRAM model: synchronous write while we_n low, combinational read.
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq_out;
    end
    assign sram_dq_in  = mem[sram_addr[3:0]];
    assign sram_dq_in2 = sram_addr2[0] ? 16'h0002 : 16'h0001;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        rst        = 1'b1;
        rst2       = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        rd_en2     = 1'b0;
        address2   = 32'd0;

        // Reset applies before any clock edge.
        #3;
        check("rst_ready", ready, 1);
        check("rst_freeze", freeze, 0);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_dq_out", sram_dq_out, 0);
        check("rst_rdata", read_data, 0);
        step();
        step();
        rst  = 1'b0;
        rst2 = 1'b0;
        step();

        // Write 0xDEADBEEF at 1028; inputs dropped mid-access.
        wr_en = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
        #1;
        check("wr_c0_ready", ready, 0);
        check("wr_c0_freeze", freeze, 1);
        step();
        wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
        #1;
        check("wr_c1_addr", sram_addr, 2);
        check("wr_c1_dq", sram_dq_out, 32'hBEEF);
        check("wr_c1_we_n", sram_we_n, 0);
        check("wr_c1_dq_oe", sram_dq_oe, 1);
        check("wr_c1_oe_n", sram_oe_n, 1);
        check("wr_c1_freeze", freeze, 1);
        step();
        check("wr_c2_addr", sram_addr, 2);
        check("wr_c2_dq", sram_dq_out, 32'hBEEF);
        check("wr_c2_we_n", sram_we_n, 0);
        step();
        check("wr_c3_addr", sram_addr, 3);
        check("wr_c3_dq", sram_dq_out, 32'hDEAD);
        check("wr_c3_we_n", sram_we_n, 0);
        step();
        check("wr_c4_addr", sram_addr, 3);
        check("wr_c4_we_n", sram_we_n, 0);
        check("wr_c4_ready", ready, 0);
        step();
        check("wr_c5_ready", ready, 1);
        check("wr_c5_we_n", sram_we_n, 1);
        check("wr_c5_dq_oe", sram_dq_oe, 0);
        check("wr_c5_addr_hold", sram_addr, 3);
        check("wr_c5_dq_hold", sram_dq_out, 32'hDEAD);
        check("wr_rdata_untouched", read_data, 0);
        step();
        check("wr_c6_ready", ready, 1);

        // Read it back.
        rd_en = 1'b1; address = 32'd1028;
        #1;
        check("rd_c0_freeze", freeze, 1);
        step();
        rd_en = 1'b0;
        #1;
        check("rd_c1_oe_n", sram_oe_n, 0);
        check("rd_c1_we_n", sram_we_n, 1);
        check("rd_c1_dq_oe", sram_dq_oe, 0);
        check("rd_c1_addr", sram_addr, 2);
        check("rd_c1_freeze", freeze, 1);
        step();
        check("rd_c2_rdata", read_data, 0);
        check("rd_c2_oe_n", sram_oe_n, 0);
        step();
        check("rd_c3_rdata", read_data, 32'h0000BEEF);
        check("rd_c3_addr", sram_addr, 3);
        check("rd_c3_oe_n", sram_oe_n, 0);
        step();
        check("rd_c4_oe_n", sram_oe_n, 0);
        check("rd_c4_freeze", freeze, 1);
        step();
        check("rd_c5_rdata", read_data, 32'hDEADBEEF);
        check("rd_c5_ready", ready, 1);
        check("rd_c5_oe_n", sram_oe_n, 1);
        step();

        // Both enables: write wins, read_data untouched.
        wr_en = 1'b1; rd_en = 1'b1; address = 32'd1024; write_data = 32'h12345678;
        #1;
        check("both_c0_ready", ready, 0);
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        #1;
        check("both_c1_addr", sram_addr, 0);
        check("both_c1_dq", sram_dq_out, 32'h5678);
        check("both_c1_we_n", sram_we_n, 0);
        check("both_c1_oe_n", sram_oe_n, 1);
        step();
        step();
        check("both_c3_addr", sram_addr, 1);
        check("both_c3_dq", sram_dq_out, 32'h1234);
        check("both_c3_oe_n", sram_oe_n, 1);
        step();
        step();
        check("both_c5_ready", ready, 1);
        check("both_c5_rdata", read_data, 32'hDEADBEEF);
        step();

        // Read at 1024, reset pulsed during the high half.
        rd_en = 1'b1; address = 32'd1024;
        step();
        rd_en = 1'b0;
        step();
        step();
        check("abort_c3_rdata", read_data, 32'hDEAD5678);
        check("abort_c3_oe_n", sram_oe_n, 0);
        check("abort_c3_addr", sram_addr, 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_oe_n", sram_oe_n, 1);
        check("abort_we_n", sram_we_n, 1);
        check("abort_dq_oe", sram_dq_oe, 0);
        check("abort_addr", sram_addr, 0);
        check("abort_dq_out", sram_dq_out, 0);
        check("abort_rdata", read_data, 0);
        check("abort_ready", ready, 1);
        #1;
        rst = 1'b0;
        step();
        check("post_rst_ready", ready, 1);
        check("post_rst_rdata", read_data, 0);
        check("post_rst_oe_n", sram_oe_n, 1);

        // Address below the base wraps.
        wr_en = 1'b1; address = 32'd0; write_data = 32'hA5A55A5A;
        step();
        wr_en = 1'b0;
        #1;
        check("wrap_c1_addr", sram_addr, 18'h3FE00);
        check("wrap_c1_dq", sram_dq_out, 32'h5A5A);
        step();
        step();
        check("wrap_c3_addr", sram_addr, 18'h3FE01);
        step();
        step();
        check("wrap_c5_ready", ready, 1);
        step();

        // Ten idle cycles.
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_ready", ready, 1);
            check("idle_freeze", freeze, 0);
            check("idle_we_n", sram_we_n, 1);
            check("idle_oe_n", sram_oe_n, 1);
            check("idle_dq_oe", sram_dq_oe, 0);
        end

        // WAIT_CYCLES=1, read held continuously: 4-cycle transactions.
        rd_en2 = 1'b1; address2 = 32'd1032;
        #1;
        check("b2b_c0_ready", ready2, 0);
        step();
        check("b2b_c1_oe_n", sram_oe_n2, 0);
        check("b2b_c1_addr", sram_addr2, 4);
        check("b2b_c1_ready", ready2, 0);
        step();
        check("b2b_c2_addr", sram_addr2, 5);
        check("b2b_c2_rdata", read_data2, 32'h00000001);
        step();
        check("b2b_c3_ready", ready2, 1);
        check("b2b_c3_rdata", read_data2, 32'h00020001);
        step();
        check("b2b_c4_ready", ready2, 0);
        check("b2b_c4_rdata", read_data2, 32'h00020001);
        step();
        check("b2b_c5_addr", sram_addr2, 4);
        check("b2b_c5_oe_n", sram_oe_n2, 0);
        step();
        step();
        check("b2b_c7_ready", ready2, 1);
        check("b2b_c7_rdata", read_data2, 32'h00020001);
        rd_en2 = 1'b0;
        step();
        step();
        check("b2b_end_ready", ready2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, clock cycles spent on each 16-bit SRAM half-access; legal range 1..15.
REQ-002 clk  input  1  single clock; all sequential logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 wr_en  input  1  store request from memory stage (STR).
REQ-005 rd_en  input  1  load request from memory stage (LDR).
REQ-006 address  input  32  byte address from ALU result.
REQ-007 write_data  input  32  store data.
REQ-008 read_data  output  32  load data, registered.
REQ-009 ready  output  1  high = no access pending or access complete this cycle.
REQ-010 freeze  output  1  pipeline stall request, equal to NOT ready.
REQ-011 sram_addr  output  18  SRAM halfword address.
REQ-012 sram_dq_out  output  16  SRAM write data.
REQ-013 sram_dq_in  input  16  SRAM read data.
REQ-014 sram_dq_oe  output  1  high = drive sram_dq_out onto the pad.
REQ-015 sram_we_n  output  1  SRAM write strobe, active-low.
REQ-016 sram_oe_n  output  1  SRAM output enable, active-low.

Function
REQ-017 FSM states IDLE, ACC_LO, ACC_HI, DONE; wait counter 4 bits.
REQ-018 IDLE: wr_en or rd_en high -> latch address, write_data, op type (write if wr_en); clear counter; go ACC_LO.
REQ-019 wr_en and rd_en both high -> write only; rd_en ignored for that transaction.
REQ-020 Effective address eff = address - 1024 (32-bit, wraps modulo 2^32); sram_addr = {eff[18:2], half}, half = 0 in ACC_LO, 1 in ACC_HI; eff[1:0] ignored.
REQ-021 ACC_LO/ACC_HI: counter increments each cycle; at count WAIT_CYCLES-1, clear counter and advance (ACC_LO->ACC_HI, ACC_HI->DONE).
REQ-022 Write states: sram_we_n=0, sram_dq_oe=1, sram_oe_n=1; sram_dq_out = data[15:0] in ACC_LO, data[31:16] in ACC_HI.
REQ-023 Read states: sram_oe_n=0, sram_we_n=1, sram_dq_oe=0; sram_dq_in captured on the last cycle of ACC_LO into read_data[15:0] and of ACC_HI into read_data[31:16].
REQ-024 DONE lasts exactly one cycle; ready=1; read_data holds the full word (reads); next state IDLE unconditionally.
REQ-025 ready = (state==DONE) OR (state==IDLE AND NOT wr_en AND NOT rd_en); combinational.
REQ-026 Latency: request seen in IDLE at cycle 0 -> ready low cycles 0..2*WAIT_CYCLES, high at cycle 2*WAIT_CYCLES+1.
REQ-027 Request held through DONE starts no new access; IDLE samples it on the following cycle as a new transaction.
REQ-028 Request deasserted or address/data changed mid-access -> latched transaction completes unchanged.
REQ-029 read_data changes only at the REQ-023 capture points; writes never modify it.
REQ-030 IDLE and DONE: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0; sram_addr and sram_dq_out hold last values.

Reset
REQ-031 rst high -> state IDLE, counter 0, latches 0, read_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1, sram_oe_n 1; takes effect without clk edge.
REQ-032 rst asserted mid-access -> access aborted, strobes released immediately, no partial read_data retained.
REQ-033 After rst release: ready=1 while no request; first request handled per REQ-018.

Verification
REQ-034 WAIT_CYCLES=2, wr_en=1, address=1028, write_data=0xDEADBEEF -> sram_addr=2 with dq_out=0xBEEF for 2 cycles, sram_addr=3 with dq_out=0xDEAD for 2 cycles, we_n low 4 cycles, ready high at cycle 5.
REQ-035 Then rd_en=1, address=1028, SRAM model returns stored halfwords -> read_data=0xDEADBEEF in DONE, freeze high cycles 0..4, sram_oe_n low 4 cycles.
REQ-036 wr_en=rd_en=1, address=1024, write_data=0x12345678 -> write at sram_addr 0/1, sram_oe_n stays 1, read_data unchanged.
REQ-037 Read started, rst pulsed during ACC_HI -> outputs at reset values immediately, read_data=0, ready=1 after release.
REQ-038 WAIT_CYCLES=1, back-to-back reads held continuously, SRAM returns 0x0001/0x0002 -> each transaction 4 cycles (IDLE, LO, HI, DONE), read_data=0x00020001.
REQ-039 No request for 10 cycles -> ready=1, freeze=0, we_n=oe_n=1, dq_oe=0 throughout.
